wb_arbiter: RTL and testbench

Writeback arbiter for the execution cluster. It collects completed results from NSRC functional units, including the multi-cycle ALU, the simple ALU and the load/store unit. Each cycle it grants one unit in round-robin order and drives the per-unit `*_stall` back-pressure signals. The granted result goes into a single registered writeback broadcast that feeds the ROB and the reservation-station wakeup logic.

---
 rtl/wb_arbiter_pkg.sv | 19 +
 rtl/flop.sv | 20 ++
 rtl/mux.sv | 20 ++
 rtl/wb_arbiter_rr_arbiter.sv | 48 ++++
 rtl/wb_arbiter.sv | 90 +++++++++
 tb/tb_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared field widths and the packed writeback record used by the writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned ROBID_W  = 7;
    localparam int unsigned RD_W     = 6;
    localparam int unsigned ECAUSE_W = 5;
    localparam int unsigned XLEN     = 32;

    typedef struct packed {
        logic                error;
        logic [ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]  robid;
        logic [RD_W-1:0]     rd;
        logic [XLEN-1:0]     result;
    } wb_fields_t;

    localparam int unsigned WB_FIELDS_W = $bits(wb_fields_t);

endpackage

// File: rtl/flop.sv
// Enabled register with asynchronous active-low clear.
module flop #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mux.sv
// One-hot select multiplexer over N packed W-bit inputs (slice i selected by sel_i[i]).
module mux #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    output logic [W-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_i[i]) begin
                data_o = data_o | data_i[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      idx;

    // Wrap is explicit so non-power-of-two N never walks past N-1.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        if (!advance_i) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selects one completed result per cycle into a
// registered broadcast for the ROB and wakeup logic, back-pressuring the rest.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NSRC = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC-1:0]          src_error,
    input  logic [ECAUSE_W*NSRC-1:0] src_ecause,
    input  logic [ROBID_W*NSRC-1:0]  src_robid,
    input  logic [RD_W*NSRC-1:0]     src_rd,
    input  logic [XLEN*NSRC-1:0]     src_result,
    output logic [NSRC-1:0]          src_stall,
    output logic                     wb_valid,
    output logic                     wb_error,
    output logic [ECAUSE_W-1:0]      wb_ecause,
    output logic [ROBID_W-1:0]       wb_robid,
    output logic [RD_W-1:0]          wb_rd,
    output logic [XLEN-1:0]          wb_result,
    input  logic                     rob_wb_stall,
    input  logic                     rob_flush
);

    logic                        accept;
    logic                        any_valid;
    logic [NSRC-1:0]             grant;
    logic [NSRC*WB_FIELDS_W-1:0] src_fields;
    wb_fields_t                  sel_fields;
    wb_fields_t                  wb_fields_q;
    logic                        wb_valid_q;
    logic                        wb_valid_d;

    assign accept     = ~rob_flush & (~wb_valid_q | ~rob_wb_stall);
    assign any_valid  = |src_valid;
    assign src_stall  = src_valid & ~(grant & {NSRC{accept}});
    assign wb_valid_d = rob_flush ? 1'b0 : any_valid;

    always_comb begin
        src_fields = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_fields[i*WB_FIELDS_W +: WB_FIELDS_W] = {src_error[i],
                                                        src_ecause[i*ECAUSE_W +: ECAUSE_W],
                                                        src_robid[i*ROBID_W +: ROBID_W],
                                                        src_rd[i*RD_W +: RD_W],
                                                        src_result[i*XLEN +: XLEN]};
        end
    end

    rr_arbiter #(.N(NSRC)) u_rr (
        .clk_i     (clk),
        .rst_ni    (rst),
        .req_i     (src_valid),
        .advance_i (accept),
        .grant_o   (grant)
    );

    mux #(.W(WB_FIELDS_W), .N(NSRC)) u_mux (
        .sel_i  (grant),
        .data_i (src_fields),
        .data_o (sel_fields)
    );

    // Valid updates on flush or accept; data only loads when a source is actually granted.
    flop #(.W(1)) u_valid_q (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (rob_flush | accept),
        .d_i    (wb_valid_d),
        .q_o    (wb_valid_q)
    );

    flop #(.W(WB_FIELDS_W)) u_fields_q (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (accept & any_valid),
        .d_i    (sel_fields),
        .q_o    (wb_fields_q)
    );

    assign wb_valid  = wb_valid_q;
    assign wb_error  = wb_fields_q.error;
    assign wb_ecause = wb_fields_q.ecause;
    assign wb_robid  = wb_fields_q.robid;
    assign wb_rd     = wb_fields_q.rd;
    assign wb_result = wb_fields_q.result;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, directed corner sequences, and randomized traffic
// checked against a round-robin reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int unsigned NSRC = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NSRC-1:0]          src_valid;
    logic [NSRC-1:0]          src_error;
    logic [ECAUSE_W*NSRC-1:0] src_ecause;
    logic [ROBID_W*NSRC-1:0]  src_robid;
    logic [RD_W*NSRC-1:0]     src_rd;
    logic [XLEN*NSRC-1:0]     src_result;
    logic [NSRC-1:0]          src_stall;
    logic                     wb_valid;
    logic                     wb_error;
    logic [ECAUSE_W-1:0]      wb_ecause;
    logic [ROBID_W-1:0]       wb_robid;
    logic [RD_W-1:0]          wb_rd;
    logic [XLEN-1:0]          wb_result;
    logic                     rob_wb_stall;
    logic                     rob_flush;

    always #5 clk = ~clk;

    wb_arbiter #(.NSRC(NSRC)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_error    (src_error),
        .src_ecause   (src_ecause),
        .src_robid    (src_robid),
        .src_rd       (src_rd),
        .src_result   (src_result),
        .src_stall    (src_stall),
        .wb_valid     (wb_valid),
        .wb_error     (wb_error),
        .wb_ecause    (wb_ecause),
        .wb_robid     (wb_robid),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .rob_wb_stall (rob_wb_stall),
        .rob_flush    (rob_flush)
    );

    int total = 0;
    int bad   = 0;

    logic [2:0]  v;
    logic        st, fl;
    logic        r_err [3];
    logic [4:0]  r_ec  [3];
    logic [6:0]  r_rid [3];
    logic [5:0]  r_rd  [3];
    logic [31:0] r_res [3];

    typedef struct {
        logic [2:0] v;
        logic       st;
        logic       fl;
        logic [2:0] stall;
        logic       wbv;
        logic [6:0] rid;
        logic       chk_rid;
        logic [1:0] ptr;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        src_valid    = v;
        rob_wb_stall = st;
        rob_flush    = fl;
        for (int i = 0; i < 3; i++) begin
            src_error[i]           = r_err[i];
            src_ecause[i*5 +: 5]   = r_ec[i];
            src_robid[i*7 +: 7]    = r_rid[i];
            src_rd[i*6 +: 6]       = r_rd[i];
            src_result[i*32 +: 32] = r_res[i];
        end
    endtask

    task automatic do_reset();
        v = '0; st = 1'b0; fl = 1'b0;
        drive();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int          m_ptr;
    logic        m_valid;
    logic [50:0] m_f;
    logic [2:0]  m_stall;
    int          g;
    logic        acc;

    initial begin
        tbl[0] = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 7'h20, 1'b1, 2'd2};
        tbl[1] = '{3'b111, 1'b0, 1'b0, 3'b011, 1'b1, 7'h41, 1'b1, 2'd0};
        tbl[2] = '{3'b111, 1'b0, 1'b0, 3'b110, 1'b1, 7'h02, 1'b1, 2'd1};
        tbl[3] = '{3'b111, 1'b1, 1'b0, 3'b111, 1'b1, 7'h02, 1'b1, 2'd1};
        tbl[4] = '{3'b101, 1'b1, 1'b1, 3'b101, 1'b0, 7'h02, 1'b1, 2'd1};
        tbl[5] = '{3'b101, 1'b1, 1'b0, 3'b001, 1'b1, 7'h45, 1'b1, 2'd0};
        tbl[6] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00, 1'b0, 2'd0};
        tbl[7] = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b1, 7'h07, 1'b1, 2'd1};
        tbl[8] = '{3'b110, 1'b0, 1'b0, 3'b100, 1'b1, 7'h28, 1'b1, 2'd2};
        tbl[9] = '{3'b011, 1'b0, 1'b0, 3'b010, 1'b1, 7'h09, 1'b1, 2'd1};

        for (int i = 0; i < 3; i++) begin
            r_err[i] = 1'b0; r_ec[i] = '0; r_rid[i] = '0; r_rd[i] = '0; r_res[i] = '0;
        end
        v = '0; st = 1'b0; fl = 1'b0;
        drive();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_valid", 64'(wb_valid), 64'(0));
        chk("reset_fields", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'(0));
        chk("reset_ptr", 64'(dut.u_rr.ptr_q), 64'(0));
        chk("reset_stall", 64'(src_stall), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 3; i++) begin
                r_rid[i] = 7'(i * 32 + k);
                r_rd[i]  = 6'(k + i);
                r_res[i] = 32'hA000_0000 + 32'(k * 16 + i);
            end
            v = tbl[k].v; st = tbl[k].st; fl = tbl[k].fl;
            drive();
            @(negedge clk);
            chk($sformatf("tbl%0d_stall", k), 64'(src_stall), 64'(tbl[k].stall));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_wb_valid", k), 64'(wb_valid), 64'(tbl[k].wbv));
            chk($sformatf("tbl%0d_ptr", k), 64'(dut.u_rr.ptr_q), 64'(tbl[k].ptr));
            if (tbl[k].chk_rid) begin
                chk($sformatf("tbl%0d_robid", k), 64'(wb_robid), 64'(tbl[k].rid));
            end
        end

        // Single source
        do_reset();
        r_rid[1] = 7'h05; r_rd[1] = 6'h12; r_res[1] = 32'hDEADBEEF; r_err[1] = 1'b0; r_ec[1] = '0;
        v = 3'b010; drive();
        @(negedge clk);
        chk("single_stall", 64'(src_stall), 64'(0));
        @(posedge clk);
        #1;
        v = '0; drive();
        chk("single_wb_valid", 64'(wb_valid), 64'(1));
        chk("single_robid", 64'(wb_robid), 64'(7'h05));
        chk("single_rd", 64'(wb_rd), 64'(6'h12));
        chk("single_result", 64'(wb_result), 64'(32'hDEADBEEF));
        chk("single_ptr", 64'(dut.u_rr.ptr_q), 64'(2));
        chk("single_stall_after", 64'(src_stall), 64'(0));

        // Back-pressure: broadcast robid 0x20 is held while source 2 waits
        r_rid[0] = 7'h20; v = 3'b001; drive();
        @(posedge clk);
        #1;
        chk("bp_setup_robid", 64'(wb_robid), 64'(7'h20));
        r_rid[2] = 7'h33; r_res[2] = 32'h1234_5678; v = 3'b100; st = 1'b1; drive();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_stall", c), 64'(src_stall), 64'(3'b100));
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_robid", c), 64'(wb_robid), 64'(7'h20));
            chk($sformatf("bp%0d_wb_valid", c), 64'(wb_valid), 64'(1));
        end
        st = 1'b0; drive();
        @(negedge clk);
        chk("bp_release_stall", 64'(src_stall), 64'(0));
        @(posedge clk);
        #1;
        v = '0; drive();
        chk("bp_release_robid", 64'(wb_robid), 64'(7'h33));
        chk("bp_release_result", 64'(wb_result), 64'(32'h1234_5678));
        chk("bp_release_ptr", 64'(dut.u_rr.ptr_q), 64'(0));

        // Asynchronous reset between edges with a valid broadcast
        #3;
        rst = 1'b0;
        #1;
        chk("async_wb_valid", 64'(wb_valid), 64'(0));
        chk("async_ptr", 64'(dut.u_rr.ptr_q), 64'(0));
        chk("async_fields", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fairness: each source drops for one cycle after its own grant
        for (int i = 0; i < 3; i++) r_rid[i] = 7'(16 + i);
        v = 3'b111;
        for (int c = 0; c < 6; c++) begin
            drive();
            @(negedge clk);
            chk($sformatf("fair%0d_stall", c), 64'(src_stall), 64'(v & ~(3'b001 << (c % 3))));
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d_robid", c), 64'(wb_robid), 64'(16 + (c % 3)));
            v = 3'b111 & ~(3'b001 << (c % 3));
        end

        // Randomized traffic against the reference model
        do_reset();
        m_ptr = 0; m_valid = 1'b0; m_f = '0; m_stall = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (fl) begin
                    v[i] = 1'b0;
                end else if (!(v[i] && m_stall[i])) begin
                    v[i]     = ($urandom_range(0, 99) < 60);
                    r_err[i] = 1'($urandom);
                    r_ec[i]  = 5'($urandom);
                    r_rid[i] = 7'($urandom);
                    r_rd[i]  = 6'($urandom);
                    r_res[i] = $urandom;
                end
            end
            st = ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 8);
            drive();

            acc = !fl && (!m_valid || !st);
            g = -1;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (m_ptr + k) % 3;
                if (g < 0 && v[idx]) g = idx;
            end
            for (int i = 0; i < 3; i++) m_stall[i] = v[i] && !(acc && g == i);

            @(negedge clk);
            chk("rnd_stall", 64'(src_stall), 64'(m_stall));
            @(posedge clk);
            #1;
            if (fl) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = (v != 3'b000);
                if (g >= 0) begin
                    m_f   = {r_err[g], r_ec[g], r_rid[g], r_rd[g], r_res[g]};
                    m_ptr = (g + 1) % 3;
                end
            end
            chk("rnd_wb_valid", 64'(wb_valid), 64'(m_valid));
            chk("rnd_ptr", 64'(dut.u_rr.ptr_q), 64'(m_ptr));
            if (m_valid) begin
                chk("rnd_fields", 64'({wb_error, wb_ecause, wb_robid, wb_rd, wb_result}), 64'(m_f));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
